// File: rtl/rng_address_gen.sv
// -----------------------------------------------------------------------------
// rng_address_gen
//
// Purpose:
//   Responder side of the start_rngAddress / done_rng_address handshake used by
//   the winner-policy FSM during exploration. A random selector `which` (masked
//   to WHICH_BITS) is reduced modulo `betterNeighborCount` (clamped to
//   MAX_NEIGHBORS) by repeated subtraction, one subtraction per enabled clock.
//   The remainder is returned as an entry index into the better-neighbour table.
//
// Ports:
//   clock                in   system clock, rising edge
//   rst                  in   asynchronous, active-high reset
//   en                   in   global enable; when low all state and outputs hold
//   start_rngAddress     in   level request, held until done is seen
//   betterNeighborCount  in   divisor, sampled in LOAD
//   which                in   random selector, sampled in LOAD, masked
//   rng_address          out  result index, held until the next LOAD
//   done_rng_address     out  one-enabled-cycle completion pulse
//   zero_count           out  sampled count was zero (valid with done)
//   busy                 out  high while in LOAD, SUB and DONE
//
// Sequence: IDLE -> LOAD -> SUB (x q) -> DONE -> RELEASE -> IDLE.
// Zero count skips SUB: IDLE -> LOAD -> DONE.
// -----------------------------------------------------------------------------
module rng_address_gen #(
    parameter int WORD_WIDTH    = 16,
    parameter int WHICH_BITS    = 4,
    parameter int MAX_NEIGHBORS = 16
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start_rngAddress,
    input  logic [WORD_WIDTH-1:0] betterNeighborCount,
    input  logic [WORD_WIDTH-1:0] which,
    output logic [WORD_WIDTH-1:0] rng_address,
    output logic                  done_rng_address,
    output logic                  zero_count,
    output logic                  busy
);

    // One extra bit so the divisor can hold MAX_NEIGHBORS (2^WHICH_BITS).
    localparam int RW = WHICH_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SUB,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t          r_state;
    logic [RW-1:0]   r_rem;
    logic [RW-1:0]   r_div;

    logic [RW-1:0]   w_which_masked;
    logic [RW-1:0]   w_count_clamped;
    logic            w_count_zero;
    logic            w_rem_ge_div;
    logic [RW-1:0]   w_rem_minus_div;
    logic            w_unused_which_hi;

    // Upper selector bits are deliberately discarded.
    assign w_which_masked    = {1'b0, which[WHICH_BITS-1:0]};
    assign w_unused_which_hi = ^which[WORD_WIDTH-1:WHICH_BITS];

    // Clamp in full width first so large counts never alias after truncation.
    assign w_count_clamped = (betterNeighborCount > WORD_WIDTH'(MAX_NEIGHBORS))
                           ? RW'(MAX_NEIGHBORS)
                           : betterNeighborCount[RW-1:0];
    assign w_count_zero    = (w_count_clamped == '0);

    assign w_rem_ge_div    = (r_rem >= r_div);
    assign w_rem_minus_div = r_rem - r_div;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_rem            <= '0;
            r_div            <= '0;
            rng_address      <= '0;
            done_rng_address <= 1'b0;
            zero_count       <= 1'b0;
            busy             <= 1'b0;
        end else if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (start_rngAddress) begin
                        r_state <= S_LOAD;
                        busy    <= 1'b1;
                    end
                end

                S_LOAD: begin
                    r_rem <= w_which_masked;
                    r_div <= w_count_clamped;
                    if (w_count_zero) begin
                        rng_address      <= '0;
                        zero_count       <= 1'b1;
                        done_rng_address <= 1'b1;
                        r_state          <= S_DONE;
                    end else begin
                        zero_count <= 1'b0;
                        r_state    <= S_SUB;
                    end
                end

                S_SUB: begin
                    // div is non-zero here, so the loop always terminates.
                    if (w_rem_ge_div) begin
                        r_rem <= w_rem_minus_div;
                    end else begin
                        rng_address      <= WORD_WIDTH'(r_rem);
                        done_rng_address <= 1'b1;
                        r_state          <= S_DONE;
                    end
                end

                S_DONE: begin
                    done_rng_address <= 1'b0;
                    busy             <= 1'b0;
                    r_state          <= S_RELEASE;
                end

                S_RELEASE: begin
                    // A still-held request must be dropped before re-arming.
                    if (!start_rngAddress) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_address_gen.sv
// -----------------------------------------------------------------------------
// tb_rng_address_gen
//
// Purpose:
//   Self-checking bench for rng_address_gen. A transaction-level model derives
//   the expected outputs from latency arithmetic (2 edges for a zero count,
//   3 + floor(rem/div) otherwise) and the modulo result; a compare process
//   checks all outputs on every falling edge. Directed requests pin the model
//   with literal latencies and results, then randomized traffic follows.
// -----------------------------------------------------------------------------
module tb_rng_address_gen;

    logic        clock = 1'b0;
    logic        rst   = 1'b0;
    logic        en    = 1'b1;
    logic        start = 1'b0;
    logic [15:0] count = '0;
    logic [15:0] which = '0;
    logic [15:0] rng_address;
    logic        done_rng_address;
    logic        zero_count;
    logic        busy;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;
    bit chk_on = 1'b0;

    rng_address_gen #(
        .WORD_WIDTH   (16),
        .WHICH_BITS   (4),
        .MAX_NEIGHBORS(16)
    ) dut (
        .clock              (clock),
        .rst                (rst),
        .en                 (en),
        .start_rngAddress   (start),
        .betterNeighborCount(count),
        .which              (which),
        .rng_address        (rng_address),
        .done_rng_address   (done_rng_address),
        .zero_count         (zero_count),
        .busy               (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int clamped(input logic [15:0] c);
        return (c > 16'd16) ? 16 : int'(c);
    endfunction

    function automatic int model_latency(input logic [15:0] w, input logic [15:0] c);
        int d;
        d = clamped(c);
        if (d == 0) return 2;
        return 3 + int'(w & 16'h000F) / d;
    endfunction

    function automatic int model_result(input logic [15:0] w, input logic [15:0] c);
        int d;
        d = clamped(c);
        if (d == 0) return 0;
        return int'(w & 16'h000F) % d;
    endfunction

    int          m_phase;   // 0 ready, 1 request in flight, 2 waiting for start low
    int          m_k;       // enabled edges since acceptance
    int          m_L;       // edge at which done rises
    logic [15:0] m_res;
    logic [15:0] e_addr;
    logic        e_done, e_zc, e_busy;

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_k     <= 0;
            m_L     <= 0;
            m_res   <= '0;
            e_addr  <= '0;
            e_done  <= 1'b0;
            e_zc    <= 1'b0;
            e_busy  <= 1'b0;
        end else if (en) begin
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1;
                    m_k     <= 1;
                    e_busy  <= 1'b1;
                end
                1: begin
                    m_k <= m_k + 1;
                    if (m_k == 1) begin
                        // inputs are taken on the second edge of the request
                        m_L   <= model_latency(which, count);
                        m_res <= 16'(model_result(which, count));
                        e_zc  <= (clamped(count) == 0);
                        if (clamped(count) == 0) begin
                            e_addr <= '0;
                            e_done <= 1'b1;
                        end
                    end else if (m_k + 1 == m_L) begin
                        e_addr <= m_res;
                        e_done <= 1'b1;
                    end else if (m_k == m_L) begin
                        m_phase <= 2;
                        e_done  <= 1'b0;
                        e_busy  <= 1'b0;
                    end
                end
                default: if (!start) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("rng_address", 32'(rng_address), 32'(e_addr));
            chk("done", 32'(done_rng_address), 32'(e_done));
            chk("zero_count", 32'(zero_count), 32'(e_zc));
            chk("busy", 32'(busy), 32'(e_busy));
            if (done_rng_address) n_done++;
        end
    end

    // ---------------- directed request with literal expectations ----------------
    task automatic do_req(input logic [15:0] w, input logic [15:0] c,
                          input int exp_addr, input int exp_zc, input int exp_edges,
                          input int hold, input int pause_at, input int pause_len,
                          input string tag);
        int edges;
        int n0;
        @(negedge clock);
        #1;
        which = w;
        count = c;
        start = 1'b1;
        n0    = n_done;
        edges = 0;
        while (edges < 80) begin
            @(posedge clock);
            #1;
            edges++;
            if (edges == pause_at) en = 1'b0;
            if (edges == pause_at + pause_len) en = 1'b1;
            if (done_rng_address) break;
        end
        chk({tag, " latency"}, 32'(edges), 32'(exp_edges));
        chk({tag, " addr"}, 32'(rng_address), 32'(exp_addr));
        chk({tag, " zero_count"}, 32'(zero_count), 32'(exp_zc));
        repeat (hold) @(negedge clock);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clock);
        chk({tag, " addr held"}, 32'(rng_address), 32'(exp_addr));
        chk({tag, " done pulses"}, 32'(n_done - n0), 32'd1);
    endtask

    function automatic logic [15:0] pick_count();
        case ($urandom % 4)
            0:       return 16'($urandom % 3);
            1:       return 16'($urandom % 17);
            2:       return 16'($urandom_range(40, 17));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("reset addr", 32'(rng_address), 32'd0);
        chk("reset done", 32'(done_rng_address), 32'd0);
        chk("reset zero_count", 32'(zero_count), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk_on = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #1 rst = 1'b0;

        do_req(16'd11,   16'd4,  3, 0, 5,  0, 0, 0, "w11c4");
        do_req(16'h00F7, 16'd7,  0, 0, 4,  0, 0, 0, "mask");
        do_req(16'd13,   16'd40, 13, 0, 3, 0, 0, 0, "clamp");
        do_req(16'd9,    16'd0,  0, 1, 2,  0, 0, 0, "zero");
        do_req(16'd11,   16'd4,  3, 0, 5, 10, 0, 0, "held");
        do_req(16'd9,    16'd5,  4, 0, 4,  0, 0, 0, "after_held");

        // abort in SUB via reset
        @(negedge clock);
        #1;
        which = 16'd15;
        count = 16'd1;
        start = 1'b1;
        repeat (6) @(posedge clock);
        #2 rst = 1'b1;
        #1;
        chk("abort addr", 32'(rng_address), 32'd0);
        chk("abort done", 32'(done_rng_address), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        @(negedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        #1 rst = 1'b0;
        do_req(16'd15, 16'd1, 0, 0, 18, 0, 0, 0, "worst");
        do_req(16'd15, 16'd1, 0, 0, 23, 0, 6, 5, "en_pause");

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            #1;
            rst   = ($urandom % 200) == 0;
            en    = ($urandom % 6) != 0;
            if (($urandom % 4) == 0) start = ~start;
            which = 16'($urandom);
            count = pick_count();
        end

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
